// File: rtl/uart_frame_ctrl.sv
// Command-frame sequencer: assembles 8-byte UART frames, validates them and issues one channel write.
// Optional macro FRAME_CHECKSUM_EN enables checking b7 against the XOR of b0..b6.
module uart_frame_ctrl #(
  parameter int         TIMEOUT_CYC = 200000,
  parameter logic [7:0] HEADER      = 8'hA5,
  parameter int         N_CH        = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        cfg_wr,
  output logic [2:0]  cfg_ch,
  output logic [31:0] cfg_delay,
  output logic [7:0]  cfg_width,
  output logic        frame_ok,
  output logic        frame_err,
  output logic        overrun,
  output logic        busy,
  output logic [7:0]  frame_cnt
);

  localparam int            TW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_CHECK, S_WRITE} state_t;

  state_t        r_state, w_state_next;
  logic [2:0]    r_idx, w_idx_next;
  logic [TW-1:0] r_tmo, w_tmo_next;
  logic [7:0]    r_frame [0:7];

  logic          r_cfg_wr, r_frame_ok, r_frame_err, r_overrun;
  logic [2:0]    r_cfg_ch;
  logic [31:0]   r_cfg_delay;
  logic [7:0]    r_cfg_width;
  logic [7:0]    r_frame_cnt;

  logic          w_store, w_wr_next, w_err_next, w_ovr_next;
  logic [7:0]    w_xor;
  logic          w_sum_ok, w_ch_ok, w_good;

  assign w_xor   = r_frame[0] ^ r_frame[1] ^ r_frame[2] ^ r_frame[3]
                 ^ r_frame[4] ^ r_frame[5] ^ r_frame[6];
  assign w_ch_ok = (r_frame[1][7:3] == 5'd0) && ({1'b0, r_frame[1][2:0]} < 4'(N_CH));

`ifdef FRAME_CHECKSUM_EN
  assign w_sum_ok = (w_xor == r_frame[7]);
`else
  // b7 is still collected so frames stay 8 bytes, but its value is ignored.
  logic w_unused_sum;
  assign w_unused_sum = ^{w_xor, r_frame[7]};
  assign w_sum_ok     = 1'b1;
`endif

  assign w_good = w_sum_ok && w_ch_ok;

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_tmo_next   = r_tmo;
    w_store      = 1'b0;
    w_wr_next    = 1'b0;
    w_err_next   = 1'b0;
    w_ovr_next   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tmo_next = '0;
        if (rx_valid && rx_data == HEADER) begin
          w_store      = 1'b1;
          w_idx_next   = 3'd1;
          w_state_next = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (rx_valid) begin
          // A mid-frame HEADER value is plain data; the 3-bit index wraps to 0 after b7.
          w_store    = 1'b1;
          w_idx_next = r_idx + 3'd1;
          w_tmo_next = '0;
          if (r_idx == 3'd7) w_state_next = S_CHECK;
        end else if (r_tmo == TO_LAST) begin
          w_err_next   = 1'b1;
          w_idx_next   = 3'd0;
          w_tmo_next   = '0;
          w_state_next = S_IDLE;
        end else begin
          w_tmo_next = r_tmo + 1'b1;
        end
      end
      S_CHECK: begin
        w_ovr_next = rx_valid;
        w_idx_next = 3'd0;
        if (w_good) begin
          w_wr_next    = 1'b1;
          w_state_next = S_WRITE;
        end else begin
          w_err_next   = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      S_WRITE: begin
        w_ovr_next   = rx_valid;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Frame bytes are only consumed after all eight have been written, so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_store) r_frame[r_idx] <= rx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= 3'd0;
      r_tmo       <= '0;
      r_cfg_wr    <= 1'b0;
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      r_cfg_ch    <= 3'd0;
      r_cfg_delay <= 32'd0;
      r_cfg_width <= 8'd0;
      r_frame_cnt <= 8'd0;
    end else begin
      r_state     <= w_state_next;
      r_idx       <= w_idx_next;
      r_tmo       <= w_tmo_next;
      r_cfg_wr    <= w_wr_next;
      r_frame_ok  <= w_wr_next;
      r_frame_err <= w_err_next;
      r_overrun   <= w_ovr_next;
      if (w_wr_next) begin
        r_cfg_ch    <= r_frame[1][2:0];
        r_cfg_delay <= {r_frame[5], r_frame[4], r_frame[3], r_frame[2]};
        r_cfg_width <= r_frame[6];
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
    end
  end

  assign cfg_wr    = r_cfg_wr;
  assign frame_ok  = r_frame_ok;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign cfg_ch    = r_cfg_ch;
  assign cfg_delay = r_cfg_delay;
  assign cfg_width = r_cfg_width;
  assign frame_cnt = r_frame_cnt;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: doc/uart_frame_ctrl.md
Name: uart_frame_ctrl

Overview:
Command-frame sequencer between the UART receiver and the pulse-generator channel registers. Consumes the receiver's byte stream and assembles fixed 8-byte configuration frames. Validates each frame's header, channel field and checksum, then issues one write strobe carrying the decoded delay and width for one generator channel. Malformed, stalled and overrun traffic is rejected with status pulses, so a partial or corrupted frame never reaches a channel register.

Parameters:
TIMEOUT_CYC, 200000, clk cycles allowed between consecutive bytes of a frame (2 ms at 100 MHz; greater than one byte time at 9600 Bd)
HEADER, 8'hA5, required value of frame byte 0
N_CH, 8, number of generator channels; valid channel indices are 0..N_CH-1 (N_CH <= 8)

Ports:
clk  in  1  system clock, 100 MHz
rst_n  in  1  asynchronous active-low reset
rx_data  in  8  received byte, valid only while rx_valid=1
rx_valid  in  1  one-cycle strobe, synchronous to clk, marks a new byte
cfg_wr  out  1  one-cycle write strobe to the channel register bank
cfg_ch  out  3  channel index for cfg_wr
cfg_delay  out  32  pulse delay in clk ticks
cfg_width  out  8  pulse width in clk ticks
frame_ok  out  1  one-cycle pulse, coincident with cfg_wr
frame_err  out  1  one-cycle pulse on checksum, channel or timeout error
overrun  out  1  one-cycle pulse when a byte arrives during CHECK or WRITE
busy  out  1  high whenever state != IDLE
frame_cnt  out  8  count of good frames; wraps 255->0

Behaviour:
- Frame layout: b0 = HEADER; b1[2:0] = channel, b1[7:3] = 0; b2..b5 = delay, LSB first; b6 = width; b7 = XOR of b0..b6.
- Reset (async assert, sync release): state IDLE, byte index 0, all outputs 0, cfg_* 0, frame_cnt 0, timeout counter 0.
- IDLE: rx_valid with rx_data==HEADER stores b0, sets index=1 and moves to COLLECT. Any other byte is silently discarded, with no error pulse.
- COLLECT: each rx_valid stores the byte at the current index and increments the index. The timeout counter clears on each accepted byte and otherwise increments each cycle.
- COLLECT, end of frame: on the clock edge that accepts b7, move to CHECK.
- COLLECT, timeout: when the counter reaches TIMEOUT_CYC-1 without a byte, pulse frame_err for one cycle, discard the partial frame and return to IDLE.
- COLLECT, HEADER value: a HEADER byte arriving mid-frame is treated as ordinary data, not a resync.
- CHECK (1 cycle): the frame is good when the checksum matches, b1[7:3]==0 and b1[2:0] < N_CH.
  - Good: go to WRITE.
  - Bad: pulse frame_err for one cycle and go to IDLE.
- WRITE (1 cycle): cfg_wr=1 and frame_ok=1, with cfg_ch, cfg_delay and cfg_width driven from the frame. frame_cnt increments. Next state is IDLE.
- Latency: cfg_wr is high in the 2nd cycle after the edge that samples b7's rx_valid. cfg_* hold their last written value between writes.
- rx_valid in CHECK or WRITE: the byte is dropped and overrun pulses the following cycle. It is not treated as a new header.
- Reset mid-frame clears everything immediately. No cfg_wr is issued for the aborted frame.
- Delay assembly: plain byte concatenation {b5,b4,b3,b2}, with no arithmetic.

Optional Feature:
Macro: FRAME_CHECKSUM_EN.
- Defined: b7 must equal the XOR of b0..b6, otherwise the frame fails with frame_err.
- Undefined: b7 is still collected (frames stay 8 bytes) but its value is ignored. Only the channel-field check can reject a frame in CHECK.

Test Plan:
1. Good frame A5 03 10 27 00 00 32 xx, with xx = correct XOR -> one cfg_wr; cfg_ch=3, cfg_delay=32'h00002710, cfg_width=8'h32; frame_ok=1; frame_cnt=1; cfg_wr high 2 cycles after b7.
2. Same frame with b7 XOR'd with 8'h01, FRAME_CHECKSUM_EN defined -> frame_err pulse, no cfg_wr, frame_cnt unchanged. Rebuilt without the macro -> cfg_wr issued.
3. Garbage bytes 00 FF 5A, then a good frame for channel 7 -> garbage produces no pulses; one cfg_wr with cfg_ch=7.
4. Channel byte 08 (N_CH=8), or 83 -> frame_err, no cfg_wr.
5. Four bytes of a frame, then silence for TIMEOUT_CYC cycles -> frame_err exactly at the timeout; busy drops; a following good frame is accepted.
6. rx_valid one cycle after b7 -> overrun pulse and the byte is dropped. Separately, rst_n low after b4 -> outputs 0, then a good frame completes with frame_cnt=1.
